// File: rtl/game_pkg.sv
// Shared constants for the game sequencer: counter control codes, winner codes and FSM states.
package game_pkg;

    localparam logic [1:0] CTRL_HOLD  = 2'b00;
    localparam logic [1:0] CTRL_UP    = 2'b01;
    localparam logic [1:0] CTRL_DOWN  = 2'b10;
    localparam logic [1:0] CTRL_LOAD  = 2'b11;

    localparam logic [1:0] WHO_NONE   = 2'b00;
    localparam logic [1:0] WHO_P1     = 2'b01;
    localparam logic [1:0] WHO_P2     = 2'b10;
    localparam logic [1:0] WHO_TIE    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_REPORT = 3'd4
    } state_e;

endpackage

// File: rtl/hold_timer.sv
// Down-counter that measures how long the sequencer stays in CLEAR.
module hold_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: loads the counter, runs a game, pulses game_reset and reports the winner.
module game_sequencer
    import game_pkg::*;
#(
    parameter int SIZE         = 4,
    parameter int RESET_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      mode_req,
    input  logic            mode_update,
    input  logic [SIZE-1:0] init_value,
    input  logic            abort,
    input  logic            gameover,
    input  logic [1:0]      who,
    input  logic            result_ack,
    output logic            init_c,
    output logic [SIZE-1:0] init_l,
    output logic [1:0]      control,
    output logic            game_reset,
    output logic            result_valid,
    output logic [1:0]      result_who,
    output logic [7:0]      games_played,
    output logic            busy
);

    state_e          state_q, state_d;
    logic            report_q, report_d;
    logic [1:0]      who_q, who_d;
    logic            timer_load_s;
    logic            timer_done_s;

    logic            init_c_q, init_c_d;
    logic [SIZE-1:0] init_l_q, init_l_d;
    logic [1:0]      control_q, control_d;
    logic            game_reset_q, game_reset_d;
    logic            result_valid_q, result_valid_d;
    logic [1:0]      result_who_q, result_who_d;
    logic [7:0]      games_played_q, games_played_d;
    logic            busy_q, busy_d;

    // The timer is armed on the edge that enters CLEAR, so CLEAR lasts RESET_CYCLES cycles.
    assign timer_load_s = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);

    hold_timer #(
        .W(4)
    ) u_hold_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (timer_load_s),
        .load_val_i (4'(RESET_CYCLES - 1)),
        .done_o     (timer_done_s)
    );

    // State register plus the winner capture and "report pending" flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            report_q <= 1'b0;
            who_q    <= WHO_NONE;
        end else begin
            state_q  <= state_d;
            report_q <= report_d;
            who_q    <= who_d;
        end
    end

    // Next-state logic; abort outranks gameover.
    always_comb begin
        state_d  = state_q;
        report_d = report_q;
        who_d    = who_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
                else       state_d = ST_IDLE;
            end
            ST_LOAD: begin
                report_d = 1'b0;
                if (abort) state_d = ST_CLEAR;
                else       state_d = ST_RUN;
            end
            ST_RUN: begin
                report_d = gameover && !abort;
                if (gameover && !abort) who_d = who;
                else                    who_d = who_q;
                if (abort || gameover) state_d = ST_CLEAR;
                else                   state_d = ST_RUN;
            end
            ST_CLEAR: begin
                if (timer_done_s) state_d = report_q ? ST_REPORT : ST_IDLE;
                else              state_d = ST_CLEAR;
            end
            ST_REPORT: begin
                if (result_ack) state_d = ST_IDLE;
                else            state_d = ST_REPORT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next-values, derived from the next state so every output is a flop.
    always_comb begin
        init_c_d       = (state_d == ST_LOAD);
        game_reset_d   = (state_d == ST_CLEAR);
        result_valid_d = (state_d == ST_REPORT);
        busy_d         = (state_d != ST_IDLE);
        result_who_d   = (state_d == ST_REPORT) ? who_d : WHO_NONE;
        init_l_d       = init_l_q;
        control_d      = control_q;
        games_played_d = games_played_q;
        if (state_q == ST_IDLE && start) begin
            init_l_d  = init_value;
            control_d = mode_req;
        end else if (state_q == ST_RUN && mode_update && !gameover && !abort) begin
            init_l_d  = init_l_q;
            control_d = mode_req;
        end else begin
            init_l_d  = init_l_q;
            control_d = control_q;
        end
        if (state_d == ST_REPORT && state_q != ST_REPORT) begin
            games_played_d = games_played_q + 8'd1;
        end else begin
            games_played_d = games_played_q;
        end
    end

    // Output registers; game_reset is asserted while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_c_q       <= 1'b0;
            init_l_q       <= {SIZE{1'b0}};
            control_q      <= CTRL_HOLD;
            game_reset_q   <= 1'b1;
            result_valid_q <= 1'b0;
            result_who_q   <= WHO_NONE;
            games_played_q <= 8'd0;
            busy_q         <= 1'b0;
        end else begin
            init_c_q       <= init_c_d;
            init_l_q       <= init_l_d;
            control_q      <= control_d;
            game_reset_q   <= game_reset_d;
            result_valid_q <= result_valid_d;
            result_who_q   <= result_who_d;
            games_played_q <= games_played_d;
            busy_q         <= busy_d;
        end
    end

    assign init_c       = init_c_q;
    assign init_l       = init_l_q;
    assign control      = control_q;
    assign game_reset   = game_reset_q;
    assign result_valid = result_valid_q;
    assign result_who   = result_who_q;
    assign games_played = games_played_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed, table-driven bench for game_sequencer with hand-computed expectations.
module tb_game_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] mode_req;
    logic       mode_update;
    logic [3:0] init_value;
    logic       abort;
    logic       gameover;
    logic [1:0] who;
    logic       result_ack;
    logic       init_c;
    logic [3:0] init_l;
    logic [1:0] control;
    logic       game_reset;
    logic       result_valid;
    logic [1:0] result_who;
    logic [7:0] games_played;
    logic       busy;

    int total;
    int bad;

    game_sequencer #(.SIZE(4), .RESET_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mode_req     (mode_req),
        .mode_update  (mode_update),
        .init_value   (init_value),
        .abort        (abort),
        .gameover     (gameover),
        .who          (who),
        .result_ack   (result_ack),
        .init_c       (init_c),
        .init_l       (init_l),
        .control      (control),
        .game_reset   (game_reset),
        .result_valid (result_valid),
        .result_who   (result_who),
        .games_played (games_played),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [1:0] mode_req;
        logic       mode_update;
        logic [3:0] init_value;
        logic       abort;
        logic       gameover;
        logic [1:0] who;
        logic       result_ack;
        logic       e_init_c;
        logic [3:0] e_init_l;
        logic [1:0] e_control;
        logic       e_game_reset;
        logic       e_result_valid;
        logic [1:0] e_result_who;
        logic [7:0] e_games_played;
        logic       e_busy;
    } vec_t;

    vec_t vecs[23];

    // Packed view: {init_c, init_l, control, game_reset, result_valid, result_who, games_played, busy}
    function automatic logic [19:0] act_pack();
        return {init_c, init_l, control, game_reset, result_valid, result_who, games_played, busy};
    endfunction

    function automatic logic [19:0] exp_pack(vec_t v);
        return {v.e_init_c, v.e_init_l, v.e_control, v.e_game_reset, v.e_result_valid,
                v.e_result_who, v.e_games_played, v.e_busy};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        start       = v.start;
        mode_req    = v.mode_req;
        mode_update = v.mode_update;
        init_value  = v.init_value;
        abort       = v.abort;
        gameover    = v.gameover;
        who         = v.who;
        result_ack  = v.result_ack;
    endtask

    task automatic idle_inputs();
        start = 1'b0; mode_req = 2'b00; mode_update = 1'b0; init_value = 4'd0;
        abort = 1'b0; gameover = 1'b0; who = 2'b00; result_ack = 1'b0;
    endtask

    // One complete reported game with winner 2'b10; waits on result_valid with a cycle budget.
    task automatic play_game();
        int n;
        start = 1'b1; init_value = 4'd6; mode_req = 2'b01;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        gameover = 1'b1; who = 2'b10;
        @(posedge clk); #1;
        gameover = 1'b0; who = 2'b00;
        n = 0;
        while (!result_valid && n < 10) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        if (!result_valid) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL report_timeout: result_valid=%0b expected 1", result_valid);
        end
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // start mode upd init abrt gov who ack | init_c init_l ctrl grst rv rwho gp busy
        vecs[0]  = '{1'b0,2'b00,1'b0,4'd0,1'b0,1'b0,2'b00,1'b0, 1'b0,4'd0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0};
        vecs[1]  = '{1'b1,2'b10,1'b0,4'd8,1'b0,1'b0,2'b00,1'b0, 1'b1,4'd8,2'b10,1'b0,1'b0,2'b00,8'd0,1'b1};
        vecs[2]  = '{1'b0,2'b00,1'b0,4'd0,1'b0,1'b0,2'b00,1'b0, 1'b0,4'd8,2'b10,1'b0,1'b0,2'b00,8'd0,1'b1};
        vecs[3]  = '{1'b0,2'b01,1'b1,4'd0,1'b0,1'b0,2'b00,1'b0, 1'b0,4'd8,2'b01,1'b0,1'b0,2'b00,8'd0,1'b1};
        vecs[4]  = '{1'b0,2'b11,1'b0,4'd0,1'b0,1'b0,2'b00,1'b0, 1'b0,4'd8,2'b01,1'b0,1'b0,2'b00,8'd0,1'b1};
        vecs[5]  = '{1'b0,2'b11,1'b1,4'd0,1'b0,1'b1,2'b01,1'b0, 1'b0,4'd8,2'b01,1'b1,1'b0,2'b00,8'd0,1'b1};
        vecs[6]  = '{1'b0,2'b00,1'b0,4'd0,1'b0,1'b0,2'b00,1'b0, 1'b0,4'd8,2'b01,1'b1,1'b0,2'b00,8'd0,1'b1};
        vecs[7]  = '{1'b0,2'b00,1'b0,4'd0,1'b0,1'b0,2'b00,1'b0, 1'b0,4'd8,2'b01,1'b0,1'b1,2'b01,8'd1,1'b1};
        vecs[8]  = '{1'b1,2'b00,1'b0,4'd0,1'b0,1'b0,2'b11,1'b0, 1'b0,4'd8,2'b01,1'b0,1'b1,2'b01,8'd1,1'b1};
        vecs[9]  = '{1'b0,2'b00,1'b1,4'd0,1'b1,1'b0,2'b11,1'b0, 1'b0,4'd8,2'b01,1'b0,1'b1,2'b01,8'd1,1'b1};
        vecs[10] = '{1'b0,2'b00,1'b0,4'd0,1'b0,1'b1,2'b11,1'b0, 1'b0,4'd8,2'b01,1'b0,1'b1,2'b01,8'd1,1'b1};
        vecs[11] = '{1'b0,2'b00,1'b0,4'd0,1'b0,1'b0,2'b11,1'b0, 1'b0,4'd8,2'b01,1'b0,1'b1,2'b01,8'd1,1'b1};
        vecs[12] = '{1'b0,2'b00,1'b0,4'd0,1'b0,1'b0,2'b00,1'b1, 1'b0,4'd8,2'b01,1'b0,1'b0,2'b00,8'd1,1'b0};
        vecs[13] = '{1'b0,2'b10,1'b1,4'd0,1'b1,1'b1,2'b01,1'b1, 1'b0,4'd8,2'b01,1'b0,1'b0,2'b00,8'd1,1'b0};
        vecs[14] = '{1'b1,2'b00,1'b0,4'd3,1'b0,1'b0,2'b00,1'b0, 1'b1,4'd3,2'b00,1'b0,1'b0,2'b00,8'd1,1'b1};
        vecs[15] = '{1'b0,2'b00,1'b0,4'd0,1'b1,1'b0,2'b00,1'b0, 1'b0,4'd3,2'b00,1'b1,1'b0,2'b00,8'd1,1'b1};
        vecs[16] = '{1'b0,2'b00,1'b0,4'd0,1'b0,1'b0,2'b00,1'b0, 1'b0,4'd3,2'b00,1'b1,1'b0,2'b00,8'd1,1'b1};
        vecs[17] = '{1'b0,2'b00,1'b0,4'd0,1'b0,1'b0,2'b00,1'b0, 1'b0,4'd3,2'b00,1'b0,1'b0,2'b00,8'd1,1'b0};
        vecs[18] = '{1'b1,2'b01,1'b0,4'd5,1'b0,1'b0,2'b00,1'b0, 1'b1,4'd5,2'b01,1'b0,1'b0,2'b00,8'd1,1'b1};
        vecs[19] = '{1'b0,2'b00,1'b0,4'd0,1'b0,1'b0,2'b00,1'b0, 1'b0,4'd5,2'b01,1'b0,1'b0,2'b00,8'd1,1'b1};
        vecs[20] = '{1'b0,2'b00,1'b0,4'd0,1'b1,1'b1,2'b10,1'b0, 1'b0,4'd5,2'b01,1'b1,1'b0,2'b00,8'd1,1'b1};
        vecs[21] = '{1'b0,2'b00,1'b0,4'd0,1'b0,1'b0,2'b00,1'b0, 1'b0,4'd5,2'b01,1'b1,1'b0,2'b00,8'd1,1'b1};
        vecs[22] = '{1'b0,2'b00,1'b0,4'd0,1'b0,1'b0,2'b00,1'b0, 1'b0,4'd5,2'b01,1'b0,1'b0,2'b00,8'd1,1'b0};

        idle_inputs();
        reset = 1'b0;
        #12;
        check("reset_state", act_pack(), {1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 2'b00, 8'd0, 1'b0});
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i]);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), act_pack(), exp_pack(vecs[i]));
        end
        idle_inputs();

        // Reset pulled low mid-RUN clears everything asynchronously.
        start = 1'b1; init_value = 4'd9; mode_req = 2'b11;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("run_before_reset", act_pack(), {1'b0, 4'd9, 2'b11, 1'b0, 1'b0, 2'b00, 8'd1, 1'b1});
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_mid_run", act_pack(), {1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 2'b00, 8'd0, 1'b0});
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("first_edge_after_reset", act_pack(), {1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0});
        @(posedge clk); #1;
        check("no_report_after_reset", act_pack(), {1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0});

        // Counter wrap after 256 reported games.
        for (int g = 0; g < 255; g++) begin
            play_game();
        end
        check("games_255", {12'd0, games_played}, {12'd0, 8'd255});
        play_game();
        check("games_wrap", {12'd0, games_played}, {12'd0, 8'd0});
        check("idle_after_wrap", act_pack(), {1'b0, 4'd6, 2'b01, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
